// File: rtl/reg_read_dispatch_pkg.sv
// Shared types for the register-read/dispatch stage: issued-entry field map,
// execute packet layout and PRF geometry.
package reg_read_dispatch_pkg;
  localparam int IQLSQ_WIDTH = 137;
  localparam int PREG_BITS   = 6;
  localparam int DATA_WIDTH  = 32;
  localparam int ROB_BITS    = 6;
  localparam int NUM_PREGS   = 1 << PREG_BITS;

  typedef logic [PREG_BITS-1:0]  preg_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ROB_BITS-1:0]   rob_t;

  // Bit-exact overlay of the issued entry, MSB first (bits 104, 89, 82 unused).
  typedef struct packed {
    logic [31:0] pc;
    logic        rsvd104;
    logic [5:0]  ctrl;
    logic        imm_src;
    logic        need_dest;
    preg_t       dest;
    logic        rsvd89;
    preg_t       src2;
    logic        rsvd82;
    preg_t       src1;
    logic [31:0] imm;
    logic [5:0]  alu_ctrl;
    rob_t        rob;
    logic [31:0] instr;
  } iss_entry_t;

  typedef struct packed {
    logic        ex_valid;
    logic        mem_valid;
    data_t       op_a;
    data_t       op_b;
    data_t       store_data;
    preg_t       dest;
    logic        need_dest;
    logic [5:0]  alu_ctrl;
    rob_t        rob;
    logic [5:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] instr;
  } ex_pkt_t;
endpackage

// File: rtl/reg_read_dispatch_if.sv
// Issue, writeback and execute-packet bundle between issue stage, this stage
// and the ALU/LSU.
interface reg_read_dispatch_if;
  import reg_read_dispatch_pkg::*;

  logic [IQLSQ_WIDTH-1:0] ISS_data_IN;
  logic                   ISS_valid_IN;
  logic                   ISS_mem_IN;
  logic                   WB0_we_IN;
  preg_t                  WB0_reg_IN;
  data_t                  WB0_data_IN;
  logic                   WB1_we_IN;
  preg_t                  WB1_reg_IN;
  data_t                  WB1_data_IN;
  logic                   EX_valid_OUT;
  logic                   MEM_valid_OUT;
  data_t                  opA_OUT;
  data_t                  opB_OUT;
  data_t                  storeData_OUT;
  preg_t                  dest_OUT;
  logic                   needDest_OUT;
  logic [5:0]             aluCtrl_OUT;
  rob_t                   rob_OUT;
  logic [5:0]             ctrl_OUT;
  logic [31:0]            pc_OUT;
  logic [31:0]            instr_OUT;
  logic [31:0]            dispCount_OUT;

  modport master (
    output ISS_data_IN, ISS_valid_IN, ISS_mem_IN,
           WB0_we_IN, WB0_reg_IN, WB0_data_IN, WB1_we_IN, WB1_reg_IN, WB1_data_IN,
    input  EX_valid_OUT, MEM_valid_OUT, opA_OUT, opB_OUT, storeData_OUT, dest_OUT,
           needDest_OUT, aluCtrl_OUT, rob_OUT, ctrl_OUT, pc_OUT, instr_OUT, dispCount_OUT
  );

  modport slave (
    input  ISS_data_IN, ISS_valid_IN, ISS_mem_IN,
           WB0_we_IN, WB0_reg_IN, WB0_data_IN, WB1_we_IN, WB1_reg_IN, WB1_data_IN,
    output EX_valid_OUT, MEM_valid_OUT, opA_OUT, opB_OUT, storeData_OUT, dest_OUT,
           needDest_OUT, aluCtrl_OUT, rob_OUT, ctrl_OUT, pc_OUT, instr_OUT, dispCount_OUT
  );
endinterface

// File: rtl/reg_read_dispatch_prf.sv
// 64-entry physical register file: two async read ports, two write ports
// with port 0 winning on a same-register collision, synchronous clear.
module phys_reg_file
  import reg_read_dispatch_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  we0_i,
  input  preg_t wa0_i,
  input  data_t wd0_i,
  input  logic  we1_i,
  input  preg_t wa1_i,
  input  data_t wd1_i,
  input  preg_t ra0_i,
  output data_t rd0_o,
  input  preg_t ra1_i,
  output data_t rd1_o
);
  data_t mem_q [NUM_PREGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PREGS; i++) mem_q[i] <= '0;
    end else begin
      // Port 1 first so a port-0 write to the same register overrides it.
      if (we1_i) mem_q[wa1_i] <= wd1_i;
      if (we0_i) mem_q[wa0_i] <= wd0_i;
    end
  end

  assign rd0_o = mem_q[ra0_i];
  assign rd1_o = mem_q[ra1_i];
endmodule

// File: rtl/reg_read_dispatch.sv
// Register-read stage: reads both sources (with same-cycle writeback bypass)
// and registers one execute packet per cycle for the ALU or LSU.
module reg_read_dispatch
  import reg_read_dispatch_pkg::*;
(
  input logic               CLK,
  input logic               RESET,
  input logic               FREEZE,
  input logic               FLUSH,
  reg_read_dispatch_if.slave bus
);
  iss_entry_t  ent;
  data_t       prf_a, prf_b, src1_val, src2_val;
  ex_pkt_t     pkt_q, pkt_d;
  logic [31:0] dispcnt_q, dispcnt_d;
  logic        unused_rsvd;

  assign ent         = iss_entry_t'(bus.ISS_data_IN);
  assign unused_rsvd = ^{ent.rsvd104, ent.rsvd89, ent.rsvd82};

  phys_reg_file u_prf (
    .clk_i (CLK),
    .rst_i (RESET),
    .we0_i (bus.WB0_we_IN),
    .wa0_i (bus.WB0_reg_IN),
    .wd0_i (bus.WB0_data_IN),
    .we1_i (bus.WB1_we_IN),
    .wa1_i (bus.WB1_reg_IN),
    .wd1_i (bus.WB1_data_IN),
    .ra0_i (ent.src1),
    .rd0_o (prf_a),
    .ra1_i (ent.src2),
    .rd1_o (prf_b)
  );

  // Bypass: WB0 beats WB1 beats the array, matching the write priority.
  always_comb begin
    src1_val = prf_a;
    src2_val = prf_b;
    if (bus.WB1_we_IN && bus.WB1_reg_IN == ent.src1) src1_val = bus.WB1_data_IN;
    if (bus.WB1_we_IN && bus.WB1_reg_IN == ent.src2) src2_val = bus.WB1_data_IN;
    if (bus.WB0_we_IN && bus.WB0_reg_IN == ent.src1) src1_val = bus.WB0_data_IN;
    if (bus.WB0_we_IN && bus.WB0_reg_IN == ent.src2) src2_val = bus.WB0_data_IN;
  end

  always_comb begin
    pkt_d     = pkt_q;
    dispcnt_d = dispcnt_q;
    if (FLUSH) begin
      pkt_d.ex_valid  = 1'b0;
      pkt_d.mem_valid = 1'b0;
    end else if (!FREEZE) begin
      pkt_d.ex_valid   = bus.ISS_valid_IN & ~bus.ISS_mem_IN;
      pkt_d.mem_valid  = bus.ISS_valid_IN &  bus.ISS_mem_IN;
      pkt_d.op_a       = src1_val;
      pkt_d.op_b       = ent.imm_src ? ent.imm : src2_val;
      pkt_d.store_data = src2_val;
      pkt_d.dest       = ent.dest;
      pkt_d.need_dest  = ent.need_dest;
      pkt_d.alu_ctrl   = ent.alu_ctrl;
      pkt_d.rob        = ent.rob;
      pkt_d.ctrl       = ent.ctrl;
      pkt_d.pc         = ent.pc;
      pkt_d.instr      = ent.instr;
      if (bus.ISS_valid_IN) dispcnt_d = dispcnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pkt_q     <= '0;
      dispcnt_q <= '0;
    end else begin
      pkt_q     <= pkt_d;
      dispcnt_q <= dispcnt_d;
    end
  end

  assign bus.EX_valid_OUT  = pkt_q.ex_valid;
  assign bus.MEM_valid_OUT = pkt_q.mem_valid;
  assign bus.opA_OUT       = pkt_q.op_a;
  assign bus.opB_OUT       = pkt_q.op_b;
  assign bus.storeData_OUT = pkt_q.store_data;
  assign bus.dest_OUT      = pkt_q.dest;
  assign bus.needDest_OUT  = pkt_q.need_dest;
  assign bus.aluCtrl_OUT   = pkt_q.alu_ctrl;
  assign bus.rob_OUT       = pkt_q.rob;
  assign bus.ctrl_OUT      = pkt_q.ctrl;
  assign bus.pc_OUT        = pkt_q.pc;
  assign bus.instr_OUT     = pkt_q.instr;
  assign bus.dispCount_OUT = dispcnt_q;
endmodule

// File: tb/tb_reg_read_dispatch.sv
// Directed scenarios plus randomized traffic checked against an array/queue
// level model of the register-read stage.
module tb_reg_read_dispatch;
  import reg_read_dispatch_pkg::*;

  logic CLK = 1'b0;
  logic RESET, FREEZE, FLUSH;
  reg_read_dispatch_if bus();

  reg_read_dispatch dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .FREEZE (FREEZE),
    .FLUSH  (FLUSH),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] m_prf [64];
  logic        m_ex, m_mem, m_need;
  logic [31:0] m_opa, m_opb, m_st, m_pc, m_instr, m_cnt;
  logic [5:0]  m_dest, m_alu, m_rob, m_ctrl;

  function automatic logic [136:0] mk_entry(input logic [31:0] pc, input logic [5:0] ctrl,
      input logic imm_src, input logic need, input logic [5:0] dest, input logic [5:0] src2,
      input logic [5:0] src1, input logic [31:0] imm, input logic [5:0] alu,
      input logic [5:0] rob, input logic [31:0] instr);
    return {pc, 1'b0, ctrl, imm_src, need, dest, 1'b0, src2, 1'b0, src1, imm, alu, rob, instr};
  endfunction

  function automatic logic [31:0] m_read(input logic [5:0] r);
    if (bus.WB0_we_IN && bus.WB0_reg_IN == r) return bus.WB0_data_IN;
    if (bus.WB1_we_IN && bus.WB1_reg_IN == r) return bus.WB1_data_IN;
    return m_prf[r];
  endfunction

  task automatic idle();
    RESET = 0; FREEZE = 0; FLUSH = 0;
    bus.ISS_valid_IN = 0; bus.ISS_mem_IN = 0; bus.ISS_data_IN = '0;
    bus.WB0_we_IN = 0; bus.WB0_reg_IN = '0; bus.WB0_data_IN = '0;
    bus.WB1_we_IN = 0; bus.WB1_reg_IN = '0; bus.WB1_data_IN = '0;
  endtask

  // Advance model and DUT by one edge with whatever inputs are applied.
  task automatic tick();
    logic [136:0] d;
    logic [31:0] a, b;
    d = bus.ISS_data_IN;
    if (RESET) begin
      for (int i = 0; i < 64; i++) m_prf[i] = '0;
      {m_ex, m_mem, m_need, m_opa, m_opb, m_st, m_pc, m_instr, m_cnt} = '0;
      {m_dest, m_alu, m_rob, m_ctrl} = '0;
    end else begin
      a = m_read(d[81:76]);
      b = m_read(d[88:83]);
      if (FLUSH) begin
        m_ex = 0; m_mem = 0;
      end else if (!FREEZE) begin
        m_ex = bus.ISS_valid_IN && !bus.ISS_mem_IN;
        m_mem = bus.ISS_valid_IN && bus.ISS_mem_IN;
        m_opa = a; m_st = b; m_opb = d[97] ? d[75:44] : b;
        m_pc = d[136:105]; m_ctrl = d[103:98]; m_need = d[96]; m_dest = d[95:90];
        m_alu = d[43:38]; m_rob = d[37:32]; m_instr = d[31:0];
        if (bus.ISS_valid_IN) m_cnt = m_cnt + 1;
      end
      if (bus.WB1_we_IN) m_prf[bus.WB1_reg_IN] = bus.WB1_data_IN;
      if (bus.WB0_we_IN) m_prf[bus.WB0_reg_IN] = bus.WB0_data_IN;
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    idle();
    bus.WB0_we_IN = 1; bus.WB0_reg_IN = 6'd5; bus.WB0_data_IN = 32'hAA;
    tick();
    idle();
    RESET = 1;
    bus.ISS_valid_IN = 1;
    bus.ISS_data_IN = mk_entry(32'h1234, 6'h3F, 0, 1, 6'd9, 6'd5, 6'd5, 32'h1, 6'h2A, 6'h11, 32'hDEAD);
    tick();
    n_vec++;
    if ({bus.EX_valid_OUT, bus.MEM_valid_OUT, bus.opA_OUT, bus.opB_OUT, bus.storeData_OUT} !== '0) begin
      n_err++; $display("FAIL reset_ops got %b %b %h %h %h want all 0", bus.EX_valid_OUT,
        bus.MEM_valid_OUT, bus.opA_OUT, bus.opB_OUT, bus.storeData_OUT);
    end
    n_vec++;
    if ({bus.dest_OUT, bus.needDest_OUT, bus.aluCtrl_OUT, bus.rob_OUT, bus.ctrl_OUT,
         bus.pc_OUT, bus.instr_OUT, bus.dispCount_OUT} !== '0) begin
      n_err++; $display("FAIL reset_fields got pc=%h instr=%h cnt=%h ctrl=%h want 0",
        bus.pc_OUT, bus.instr_OUT, bus.dispCount_OUT, bus.ctrl_OUT);
    end
    RESET = 0;
    tick();
    n_vec++;
    if (bus.EX_valid_OUT !== 1'b1 || bus.opA_OUT !== 32'h0) begin
      n_err++; $display("FAIL reset_prf got ex=%b opA=%h want ex=1 opA=0", bus.EX_valid_OUT, bus.opA_OUT);
    end
    idle();
  endtask

  task automatic test_basic();
    idle();
    bus.WB0_we_IN = 1; bus.WB0_reg_IN = 6'd3; bus.WB0_data_IN = 32'h11;
    bus.WB1_we_IN = 1; bus.WB1_reg_IN = 6'd4; bus.WB1_data_IN = 32'h22;
    tick();
    idle();
    bus.ISS_valid_IN = 1;
    bus.ISS_data_IN = mk_entry(32'h400, 6'h20, 0, 1, 6'd12, 6'd4, 6'd3, 32'h5555, 6'h07, 6'h21, 32'hCAFE);
    tick();
    n_vec++;
    if (bus.EX_valid_OUT !== 1 || bus.MEM_valid_OUT !== 0 || bus.opA_OUT !== 32'h11 || bus.opB_OUT !== 32'h22) begin
      n_err++; $display("FAIL basic_ops got ex=%b mem=%b a=%h b=%h want 1 0 11 22", bus.EX_valid_OUT,
        bus.MEM_valid_OUT, bus.opA_OUT, bus.opB_OUT);
    end
    n_vec++;
    if ({bus.pc_OUT, bus.ctrl_OUT, bus.dest_OUT, bus.needDest_OUT, bus.aluCtrl_OUT, bus.rob_OUT, bus.instr_OUT}
        !== {32'h400, 6'h20, 6'd12, 1'b1, 6'h07, 6'h21, 32'hCAFE}) begin
      n_err++; $display("FAIL basic_fields got pc=%h ctrl=%h dest=%0d alu=%h rob=%h instr=%h", bus.pc_OUT,
        bus.ctrl_OUT, bus.dest_OUT, bus.aluCtrl_OUT, bus.rob_OUT, bus.instr_OUT);
    end
    n_vec++;
    if (bus.dispCount_OUT !== 32'd2) begin
      n_err++; $display("FAIL basic_count got %0d want 2", bus.dispCount_OUT);
    end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    bus.ISS_valid_IN = 1;
    bus.ISS_data_IN = mk_entry(32'h8, 6'h0, 0, 0, 6'd0, 6'd7, 6'd7, 32'h0, 6'h0, 6'h1, 32'h0);
    bus.WB1_we_IN = 1; bus.WB1_reg_IN = 6'd7; bus.WB1_data_IN = 32'h5;
    tick();
    n_vec++;
    if (bus.opA_OUT !== 32'h5) begin
      n_err++; $display("FAIL bypass_wb1 got %h want 5", bus.opA_OUT);
    end
    bus.WB0_we_IN = 1; bus.WB0_reg_IN = 6'd7; bus.WB0_data_IN = 32'h9;
    tick();
    n_vec++;
    if (bus.opA_OUT !== 32'h9 || bus.opB_OUT !== 32'h9) begin
      n_err++; $display("FAIL bypass_wb0_prio got a=%h b=%h want 9 9", bus.opA_OUT, bus.opB_OUT);
    end
    bus.WB0_we_IN = 0; bus.WB1_we_IN = 0;
    tick();
    n_vec++;
    if (bus.opA_OUT !== 32'h9) begin
      n_err++; $display("FAIL prf_wb0_prio got %h want 9", bus.opA_OUT);
    end
    idle();
  endtask

  task automatic test_imm_store();
    idle();
    bus.WB1_we_IN = 1; bus.WB1_reg_IN = 6'd8; bus.WB1_data_IN = 32'h77;
    tick();
    idle();
    bus.ISS_valid_IN = 1; bus.ISS_mem_IN = 1;
    bus.ISS_data_IN = mk_entry(32'h20, 6'h02, 1, 0, 6'd0, 6'd8, 6'd3, 32'hFFFF_FFFC, 6'h0, 6'h3, 32'h1);
    tick();
    n_vec++;
    if (bus.MEM_valid_OUT !== 1 || bus.EX_valid_OUT !== 0 || bus.opB_OUT !== 32'hFFFF_FFFC ||
        bus.storeData_OUT !== 32'h77) begin
      n_err++; $display("FAIL imm_store got mem=%b ex=%b b=%h st=%h want 1 0 fffffffc 77",
        bus.MEM_valid_OUT, bus.EX_valid_OUT, bus.opB_OUT, bus.storeData_OUT);
    end
    idle();
  endtask

  task automatic test_freeze_flush();
    logic [31:0] cnt_before;
    idle();
    bus.ISS_valid_IN = 1;
    bus.ISS_data_IN = mk_entry(32'h1000, 6'h10, 0, 1, 6'd20, 6'd4, 6'd3, 32'h0, 6'h5, 6'h6, 32'hBEEF);
    tick();
    cnt_before = m_cnt;
    FREEZE = 1;
    for (int i = 0; i < 3; i++) begin
      bus.ISS_data_IN = {$urandom, $urandom, $urandom, $urandom, $urandom} ;
      bus.WB0_we_IN = (i == 1); bus.WB0_reg_IN = 6'd3; bus.WB0_data_IN = 32'h3333;
      tick();
      n_vec++;
      if (bus.EX_valid_OUT !== 1 || bus.pc_OUT !== 32'h1000 || bus.opA_OUT !== 32'h11 ||
          bus.instr_OUT !== 32'hBEEF || bus.dispCount_OUT !== cnt_before) begin
        n_err++; $display("FAIL freeze_hold%0d got ex=%b pc=%h a=%h instr=%h cnt=%0d want 1 1000 11 beef %0d",
          i, bus.EX_valid_OUT, bus.pc_OUT, bus.opA_OUT, bus.instr_OUT, bus.dispCount_OUT, cnt_before);
      end
    end
    idle();
    bus.ISS_valid_IN = 1;
    bus.ISS_data_IN = mk_entry(32'h2000, 6'h0, 0, 1, 6'd1, 6'd4, 6'd3, 32'h0, 6'h0, 6'h7, 32'h0);
    tick();
    n_vec++;
    if (bus.opA_OUT !== 32'h3333) begin
      n_err++; $display("FAIL freeze_wb got %h want 3333", bus.opA_OUT);
    end
    FREEZE = 1; FLUSH = 1;
    tick();
    n_vec++;
    if (bus.EX_valid_OUT !== 0 || bus.MEM_valid_OUT !== 0 || bus.dispCount_OUT !== cnt_before + 1) begin
      n_err++; $display("FAIL flush got ex=%b mem=%b cnt=%0d want 0 0 %0d", bus.EX_valid_OUT,
        bus.MEM_valid_OUT, bus.dispCount_OUT, cnt_before + 1);
    end
    idle();
  endtask

  task automatic test_counter();
    idle();
    force dut.dispcnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.dispcnt_q;
    m_cnt = 32'hFFFF_FFFF;
    bus.ISS_valid_IN = 1; bus.ISS_mem_IN = 1;
    tick();
    n_vec++;
    if (bus.dispCount_OUT !== 32'h0 || bus.MEM_valid_OUT !== 1) begin
      n_err++; $display("FAIL count_wrap got cnt=%h mem=%b want 0 1", bus.dispCount_OUT, bus.MEM_valid_OUT);
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RESET  = ($urandom_range(63) == 0);
      FREEZE = ($urandom_range(4) == 0);
      FLUSH  = ($urandom_range(7) == 0);
      bus.ISS_valid_IN = $urandom_range(1);
      bus.ISS_mem_IN   = $urandom_range(1);
      bus.ISS_data_IN  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      bus.ISS_data_IN[88:83] = 6'($urandom_range(7));
      bus.ISS_data_IN[81:76] = 6'($urandom_range(7));
      bus.WB0_we_IN = $urandom_range(1); bus.WB0_reg_IN = 6'($urandom_range(7)); bus.WB0_data_IN = $urandom;
      bus.WB1_we_IN = $urandom_range(1); bus.WB1_reg_IN = 6'($urandom_range(7)); bus.WB1_data_IN = $urandom;
      tick();
      n_vec++;
      if ({bus.EX_valid_OUT, bus.MEM_valid_OUT, bus.dispCount_OUT} !== {m_ex, m_mem, m_cnt}) begin
        n_err++; $display("FAIL rnd%0d_valid got ex=%b mem=%b cnt=%0d want %b %b %0d", i, bus.EX_valid_OUT,
          bus.MEM_valid_OUT, bus.dispCount_OUT, m_ex, m_mem, m_cnt);
      end
      if (m_ex || m_mem) begin
        n_vec++;
        if ({bus.opA_OUT, bus.opB_OUT, bus.storeData_OUT} !== {m_opa, m_opb, m_st}) begin
          n_err++; $display("FAIL rnd%0d_ops got %h %h %h want %h %h %h", i, bus.opA_OUT, bus.opB_OUT,
            bus.storeData_OUT, m_opa, m_opb, m_st);
        end
        n_vec++;
        if ({bus.pc_OUT, bus.ctrl_OUT, bus.needDest_OUT, bus.dest_OUT, bus.aluCtrl_OUT, bus.rob_OUT, bus.instr_OUT}
            !== {m_pc, m_ctrl, m_need, m_dest, m_alu, m_rob, m_instr}) begin
          n_err++; $display("FAIL rnd%0d_fields got pc=%h ctrl=%h dest=%h instr=%h want %h %h %h %h", i,
            bus.pc_OUT, bus.ctrl_OUT, bus.dest_OUT, bus.instr_OUT, m_pc, m_ctrl, m_dest, m_instr);
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    RESET = 1;
    tick();
    tick();
    RESET = 0;
    test_reset();
    test_basic();
    test_bypass();
    test_imm_store();
    test_freeze_flush();
    test_counter();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
